// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared defaults and next-PC source encoding for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          STEP_DEF     = 4;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;

    typedef enum logic [2:0] {
        REDIRECT = 3'd0,
        HOLD     = 3'd1,
        CALL     = 3'd2,
        RET      = 3'd3,
        SEQ      = 3'd4
    } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack; a push when full overwrites
//               the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       top,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_top_idx;

    // r_ptr names the next free slot; when full it also names the oldest entry.
    assign w_top_idx = r_ptr - PW'(1);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
            count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && (count != '0)) begin
            r_ptr <= w_top_idx;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            r_mem[r_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC register with prioritised redirect/stall/call/ret
//               selection and a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              NRED      = 4,
    parameter int              RAS_DEPTH = 4,
    parameter int              STEP      = STEP_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [NRED-1:0]            redirect_valid,
    input  logic [NRED*XLEN-1:0]       redirect_addr,
    input  logic                       call,
    input  logic [XLEN-1:0]            call_target,
    input  logic                       ret,
    output logic [XLEN-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ret_underflow,
    output logic                       misalign_err
);

    pc_src_e         w_src;
    logic [XLEN-1:0] w_red_addr;
    logic [XLEN-1:0] w_step_pc;
    logic [XLEN-1:0] w_ras_top;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_underflow;
    logic            w_misalign;

    assign w_step_pc = pc + XLEN'(STEP);

    // Descending scan so the lowest-index asserted channel is the last writer.
    always_comb begin
        w_red_addr = '0;
        for (int i = NRED - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                w_red_addr = redirect_addr[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_src       = SEQ;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (|redirect_valid) begin
            w_src = REDIRECT;
        end else if (stall) begin
            w_src = HOLD;
        end else if (call) begin
            w_src  = CALL;
            w_push = 1'b1;
        end else if (ret) begin
            if (ras_count != '0) begin
                w_src = RET;
                w_pop = 1'b1;
            end else begin
                w_underflow = 1'b1;
            end
        end
    end

    always_comb begin
        w_target   = w_step_pc;
        w_next_pc  = w_step_pc;
        w_misalign = 1'b0;
        case (w_src)
            REDIRECT: w_target = w_red_addr;
            HOLD:     w_target = pc;
            CALL:     w_target = call_target;
            RET:      w_target = w_ras_top;
            default:  w_target = w_step_pc;
        endcase
        // Only jump targets are alignment-checked; hold and step keep pc as is.
        if (w_src == REDIRECT || w_src == CALL || w_src == RET) begin
            w_next_pc  = {w_target[XLEN-1:2], 2'b00};
            w_misalign = |w_target[1:0];
        end else begin
            w_next_pc  = w_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            ret_underflow <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            pc            <= w_next_pc;
            ret_underflow <= w_underflow;
            misalign_err  <= w_misalign;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_step_pc),
        .top       (w_ras_top),
        .count     (ras_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed and randomized checking of pc_sequencer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int NRED  = 4;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             stall;
    logic [NRED-1:0]  redirect_valid;
    logic [NRED*32-1:0] redirect_addr;
    logic             call;
    logic [31:0]      call_target;
    logic             ret;
    logic [31:0]      pc;
    logic [2:0]       ras_count;
    logic             ret_underflow;
    logic             misalign_err;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf;
    logic        m_mis;

    always #5 clock = ~clock;

    pc_sequencer #(
        .XLEN      (32),
        .NRED      (NRED),
        .RAS_DEPTH (DEPTH),
        .STEP      (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .call           (call),
        .call_target    (call_target),
        .ret            (ret),
        .pc             (pc),
        .ras_count      (ras_count),
        .ret_underflow  (ret_underflow),
        .misalign_err   (misalign_err)
    );

    task automatic model_update();
        logic [31:0] t;
        int          sel;
        if (reset) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_uf = 1'b0;
            m_mis = 1'b0;
        end else if (redirect_valid != '0) begin
            sel = 0;
            while (!redirect_valid[sel]) sel++;
            t = redirect_addr[sel*32 +: 32];
            m_mis = (t[1:0] != 2'b00);
            m_pc = t & 32'hFFFF_FFFC;
            m_uf = 1'b0;
        end else if (stall) begin
            m_uf = 1'b0;
            m_mis = 1'b0;
        end else if (call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            m_mis = (call_target[1:0] != 2'b00);
            m_pc = call_target & 32'hFFFF_FFFC;
            m_uf = 1'b0;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                t = m_ras.pop_back();
                m_mis = (t[1:0] != 2'b00);
                m_pc = t & 32'hFFFF_FFFC;
                m_uf = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
                m_uf = 1'b1;
                m_mis = 1'b0;
            end
        end else begin
            m_pc = m_pc + 32'd4;
            m_uf = 1'b0;
            m_mis = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("ras_count", {29'd0, ras_count}, m_ras.size());
        chk("ret_underflow", {31'd0, ret_underflow}, {31'd0, m_uf});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic rs, input logic st, input logic [NRED-1:0] rv,
                        input logic [NRED*32-1:0] ra, input logic cl,
                        input logic [31:0] ct, input logic rt);
        reset = rs; stall = st; redirect_valid = rv; redirect_addr = ra;
        call = cl; call_target = ct; ret = rt;
        model_update();
        @(posedge clock);
        #1;
        vectors++;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic redir(input logic [31:0] a);
        step(1'b0, 1'b0, 4'b0001, {96'h0, a}, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_call(input logic [31:0] t);
        step(1'b0, 1'b0, '0, '0, 1'b1, t, 1'b0);
    endtask

    task automatic do_ret();
        step(1'b0, 1'b0, '0, '0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    initial begin
        logic [NRED-1:0]    rv;
        logic [NRED*32-1:0] ra;
        logic [31:0]        a;
        logic [31:0]        ct;
        logic [31:0]        exp_ret[4];

        // Reset then free run
        step(1'b1, 1'b1, 4'b1111, {4{32'h123}}, 1'b1, 32'h55, 1'b1);
        lit("reset_pc", pc, m_pc, 32'h0);
        lit("reset_cnt", {29'd0, ras_count}, m_ras.size(), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            lit("freerun_pc", pc, m_pc, 32'(i * 4));
        end

        // Redirect priority, also while stalled
        step(1'b0, 1'b0, 4'b0110, {32'h0, 32'h200, 32'h100, 32'h0}, 1'b1, 32'h900, 1'b0);
        lit("redir_lowest", pc, m_pc, 32'h100);
        step(1'b0, 1'b1, 4'b0110, {32'h0, 32'h200, 32'h100, 32'h0}, 1'b0, 32'h0, 1'b0);
        lit("redir_stall", pc, m_pc, 32'h100);
        step(1'b0, 1'b1, 4'b0000, '0, 1'b1, 32'h900, 1'b1);
        lit("stall_hold", pc, m_pc, 32'h100);

        // Call then return
        redir(32'h40);
        do_call(32'h800);
        lit("call_pc", pc, m_pc, 32'h800);
        lit("call_cnt", {29'd0, ras_count}, m_ras.size(), 32'd1);
        do_ret();
        lit("ret_pc", pc, m_pc, 32'h44);
        lit("ret_cnt", {29'd0, ras_count}, m_ras.size(), 32'd0);

        // Five calls into a four-deep stack, then five returns
        redir(32'h1000);
        for (int i = 0; i < 5; i++) do_call(32'h2000 + 32'(i) * 32'h100);
        lit("full_cnt", {29'd0, ras_count}, m_ras.size(), 32'd4);
        exp_ret[0] = 32'h2304; exp_ret[1] = 32'h2204;
        exp_ret[2] = 32'h2104; exp_ret[3] = 32'h2004;
        for (int i = 0; i < 4; i++) begin
            do_ret();
            lit("nested_ret", pc, m_pc, exp_ret[i]);
        end
        do_ret();
        lit("underflow_pc", pc, m_pc, 32'h2008);
        lit("underflow_flag", {31'd0, ret_underflow}, {31'd0, m_uf}, 32'd1);
        idle();
        lit("underflow_pulse", {31'd0, ret_underflow}, {31'd0, m_uf}, 32'd0);

        // Wrap and misaligned redirect
        redir(32'hFFFF_FFFC);
        idle();
        lit("wrap_pc", pc, m_pc, 32'h0);
        redir(32'h103);
        lit("misalign_pc", pc, m_pc, 32'h100);
        lit("misalign_flag", {31'd0, misalign_err}, {31'd0, m_mis}, 32'd1);
        idle();
        lit("misalign_pulse", {31'd0, misalign_err}, {31'd0, m_mis}, 32'd0);

        // Reset discards stack
        do_call(32'h3000);
        do_call(32'h4000);
        step(1'b1, 1'b0, '0, '0, 1'b1, 32'h5000, 1'b0);
        lit("rst_mid_pc", pc, m_pc, 32'h0);
        lit("rst_mid_cnt", {29'd0, ras_count}, m_ras.size(), 32'd0);
        do_ret();
        lit("rst_ret_uf", {31'd0, ret_underflow}, {31'd0, m_uf}, 32'd1);
        lit("rst_ret_pc", pc, m_pc, 32'h4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rv = '0;
            for (int c = 0; c < NRED; c++) rv[c] = ($urandom_range(11) == 0);
            for (int c = 0; c < NRED; c++) begin
                a = $urandom;
                if ($urandom_range(3) != 0) a[1:0] = 2'b00;
                if ($urandom_range(15) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
                ra[c*32 +: 32] = a;
            end
            ct = $urandom;
            if ($urandom_range(3) != 0) ct[1:0] = 2'b00;
            step(($urandom_range(63) == 0), ($urandom_range(5) == 0), rv, ra,
                 ($urandom_range(3) == 0), ct, ($urandom_range(2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
